// File: rtl/key_search_ctrl.sv
// key_search_ctrl: initiator for the key-increment and decrypt-check handshakes.
// Walks candidate keys from KEY_INIT and stops on the first valid key (found)
// or when the key space runs out (failed).
// Ports: clk, reset (sync, active-high), go;
//   key_start/key_finish/key_exhausted/key_in to the incrementer;
//   key_out to the incrementer and decrypt core;
//   dec_start/dec_finish/dec_valid to the decrypt core;
//   busy/found/failed/timeout/attempts as status.
// Build option: define KEY_SEARCH_TIMEOUT_EN to enable the handshake watchdog.
`timescale 1ns/1ps
module key_search_ctrl #(
    parameter int unsigned      KEY_W          = 24,
    parameter logic [KEY_W-1:0] KEY_INIT       = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_LIMIT      = 24'h400000,
    parameter int unsigned      TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    output logic             key_start,
    input  logic             key_finish,
    input  logic             key_exhausted,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_out,
    output logic             dec_start,
    input  logic             dec_finish,
    input  logic             dec_valid,
    output logic             busy,
    output logic             found,
    output logic             failed,
    output logic             timeout,
    output logic [KEY_W-1:0] attempts
);

    typedef enum logic [2:0] {
        IDLE,
        DEC_REQ,
        DEC_WAIT,
        KEY_HOLD,
        KEY_REQ,
        KEY_WAIT,
        FOUND,
        FAIL
    } state_e;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] att_q, att_d;
    logic             timeout_q, timeout_d;
    logic             kfin_q, dfin_q;
    logic             kfin_rise, dfin_rise;

    assign kfin_rise = key_finish & ~kfin_q;
    assign dfin_rise = dec_finish & ~dfin_q;

`ifdef KEY_SEARCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    // Fires on the TIMEOUT_CYCLES-th cycle spent in a wait state.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Any state change clears the counter, so it restarts on every
    // entry into DEC_WAIT or KEY_WAIT.
    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (state_q == DEC_WAIT || state_q == KEY_WAIT) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        att_d     = att_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE, FOUND, FAIL: begin
                if (go) begin
                    state_d   = DEC_REQ;
                    key_d     = KEY_INIT;
                    att_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            DEC_REQ: state_d = DEC_WAIT;
            DEC_WAIT: begin
                if (dfin_rise) begin
                    if (dec_valid) begin
                        state_d = FOUND;
                    end else begin
                        if (att_q != '1) begin
                            att_d = att_q + KEY_W'(1);
                        end
                        // Skip KEY_HOLD when the incrementer is already idle.
                        if (key_q == KEY_LIMIT) begin
                            state_d = FAIL;
                        end else if (key_finish) begin
                            state_d = KEY_HOLD;
                        end else begin
                            state_d = KEY_REQ;
                        end
                    end
                end
`ifdef KEY_SEARCH_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = FAIL;
                    timeout_d = 1'b1;
                end
`endif
            end
            KEY_HOLD: begin
                if (!key_finish) begin
                    state_d = KEY_REQ;
                end
            end
            KEY_REQ: state_d = KEY_WAIT;
            KEY_WAIT: begin
                if (key_exhausted) begin
                    state_d = FAIL;
                end else if (kfin_rise) begin
                    key_d   = key_in;
                    state_d = DEC_REQ;
                end
`ifdef KEY_SEARCH_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d   = FAIL;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            key_q     <= '0;
            att_q     <= '0;
            timeout_q <= 1'b0;
            kfin_q    <= 1'b0;
            dfin_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            att_q     <= att_d;
            timeout_q <= timeout_d;
            kfin_q    <= key_finish;
            dfin_q    <= dec_finish;
        end
    end

    assign key_start = (state_q == KEY_REQ);
    assign dec_start = (state_q == DEC_REQ);
    assign found     = (state_q == FOUND);
    assign failed    = (state_q == FAIL);
    assign busy      = !(state_q == IDLE || state_q == FOUND || state_q == FAIL);
    assign timeout   = timeout_q;
    assign key_out   = key_q;
    assign attempts  = att_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: bench for key_search_ctrl with behavioural
// incrementer and decrypt-core responders and a result/key scoreboard.
`timescale 1ns/1ps
module tb_key_search_ctrl;

    localparam int KW = 24;
    localparam logic [KW-1:0] LIM  = 24'h000040;
    localparam logic [KW-1:0] NONE = 24'hFFFFFF;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0;
    logic key_start, key_finish, key_exhausted;
    logic dec_start, dec_finish, dec_valid;
    logic busy, found, failed, timeout;
    logic [KW-1:0] key_in, key_out, attempts;

    always #5 clk = ~clk;

    key_search_ctrl #(
        .KEY_W(KW),
        .KEY_INIT(24'h000000),
        .KEY_LIMIT(LIM),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .key_start(key_start),
        .key_finish(key_finish),
        .key_exhausted(key_exhausted),
        .key_in(key_in),
        .key_out(key_out),
        .dec_start(dec_start),
        .dec_finish(dec_finish),
        .dec_valid(dec_valid),
        .busy(busy),
        .found(found),
        .failed(failed),
        .timeout(timeout),
        .attempts(attempts)
    );

    typedef struct packed {
        logic          fnd;
        logic          fl;
        logic [KW-1:0] key;
        logic [KW-1:0] att;
        logic [7:0]    inc;
    } res_t;

    res_t          exp_q[$];
    logic [KW-1:0] kexp_q[$];
    logic [KW-1:0] kobs_q[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [KW-1:0] valid_key = NONE;
    logic [KW-1:0] hang_key = NONE;
    int            inc_mode = 0;
    bit            inc_exhaust = 1'b0;
    int            inc_pulses = 0;
    int            inc_calls = 0;

    function automatic string fmt(input res_t r);
        return $sformatf("found=%b failed=%b key=%h att=%0d inc=%0d",
                         r.fnd, r.fl, r.key, r.att, r.inc);
    endfunction

    // Incrementer: one idle cycle after key_start, then key_finish for 2 cycles.
    initial begin
        key_finish = 1'b0;
        key_exhausted = 1'b0;
        key_in = '0;
        forever begin
            @(negedge clk);
            if (key_start) begin
                inc_pulses++;
                @(negedge clk);
                if (inc_mode == 1) key_in = LIM;
                else if (inc_mode == 2 && inc_calls == 0) key_in = '0;
                else key_in = key_out + 24'd1;
                inc_calls++;
                if (inc_exhaust) begin
                    key_exhausted = 1'b1;
                    key_in = 24'hABCDEF;
                end else begin
                    kexp_q.push_back(key_in);
                end
                key_finish = 1'b1;
                @(negedge clk);
                @(negedge clk);
                key_finish = 1'b0;
            end
        end
    end

    // Decrypt core: finish pulse two cycles after dec_start, unless hanging.
    initial begin
        dec_finish = 1'b0;
        dec_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (dec_start) begin
                kobs_q.push_back(key_out);
                if (key_out != hang_key) begin
                    @(negedge clk);
                    @(negedge clk);
                    dec_valid = (key_out == valid_key);
                    dec_finish = 1'b1;
                    @(negedge clk);
                    dec_finish = 1'b0;
                    dec_valid = 1'b0;
                end
            end
        end
    end

    task automatic start_search(input logic [KW-1:0] vk, input int mode,
                                input logic [KW-1:0] hk, input bit exh);
        repeat (4) @(negedge clk);
        key_exhausted = 1'b0;
        valid_key = vk;
        inc_mode = mode;
        hang_key = hk;
        inc_exhaust = exh;
        inc_pulses = 0;
        inc_calls = 0;
        kexp_q.delete();
        kobs_q.delete();
        kexp_q.push_back(24'h000000);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (found || failed) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, found, failed, timeout, key_start, dec_start} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000000",
                     {busy, found, failed, timeout, key_start, dec_start});
        end
        n_cmp++;
        if ({key_out, attempts} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_regs got key=%h att=%h want 0", key_out, attempts);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_first_hit();
        res_t e, o;
        logic [KW-1:0] a, b;
        bit ok;
        start_search(24'h000000, 0, NONE, 1'b0);
        n_cmp++;
        if (dec_start !== 1'b1) begin
            n_err++;
            $display("FAIL first_latency dec_start=%b want 1", dec_start);
        end
        exp_q.push_back('{1'b1, 1'b0, 24'h000000, 24'd0, 8'd0});
        wait_done(500, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL first_done got timeout want done");
        end
        e = exp_q.pop_front();
        o = '{found, failed, key_out, attempts, 8'(inc_pulses)};
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL first_result got %s want %s", fmt(o), fmt(e));
        end
        n_cmp++;
        if (kobs_q.size() != kexp_q.size()) begin
            n_err++;
            $display("FAIL first_keycount got %0d want %0d", kobs_q.size(), kexp_q.size());
        end
        while (kobs_q.size() > 0 && kexp_q.size() > 0) begin
            a = kobs_q.pop_front();
            b = kexp_q.pop_front();
            n_cmp++;
            if (a !== b) begin
                n_err++;
                $display("FAIL first_key got %h want %h", a, b);
            end
        end
    endtask

    task automatic test_walk_go_ignored();
        res_t e, o;
        logic [KW-1:0] a, b;
        bit ok;
        start_search(24'h000005, 0, NONE, 1'b0);
        exp_q.push_back('{1'b1, 1'b0, 24'h000005, 24'd5, 8'd5});
        repeat (8) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(500, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL walk_done got timeout want done");
        end
        e = exp_q.pop_front();
        o = '{found, failed, key_out, attempts, 8'(inc_pulses)};
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL walk_result got %s want %s", fmt(o), fmt(e));
        end
        n_cmp++;
        if (kobs_q.size() != 6 || kexp_q.size() != 6) begin
            n_err++;
            $display("FAIL walk_keycount got %0d want 6 (exp %0d)", kobs_q.size(), kexp_q.size());
        end
        while (kobs_q.size() > 0 && kexp_q.size() > 0) begin
            a = kobs_q.pop_front();
            b = kexp_q.pop_front();
            n_cmp++;
            if (a !== b) begin
                n_err++;
                $display("FAIL walk_key got %h want %h", a, b);
            end
        end
    endtask

    task automatic test_limit();
        res_t e, o;
        logic [KW-1:0] a, b;
        bit ok;
        start_search(NONE, 1, NONE, 1'b0);
        n_cmp++;
        if ({found, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL limit_restart got found=%b busy=%b want 0 1", found, busy);
        end
        exp_q.push_back('{1'b0, 1'b1, LIM, 24'd2, 8'd1});
        wait_done(500, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL limit_done got timeout want done");
        end
        e = exp_q.pop_front();
        o = '{found, failed, key_out, attempts, 8'(inc_pulses)};
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL limit_result got %s want %s", fmt(o), fmt(e));
        end
        while (kobs_q.size() > 0 && kexp_q.size() > 0) begin
            a = kobs_q.pop_front();
            b = kexp_q.pop_front();
            n_cmp++;
            if (a !== b) begin
                n_err++;
                $display("FAIL limit_key got %h want %h", a, b);
            end
        end
    endtask

    task automatic test_wrap();
        res_t e, o;
        logic [KW-1:0] a, b;
        bit ok;
        start_search(24'h000001, 2, NONE, 1'b0);
        exp_q.push_back('{1'b1, 1'b0, 24'h000001, 24'd2, 8'd2});
        wait_done(500, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wrap_done got timeout want done");
        end
        e = exp_q.pop_front();
        o = '{found, failed, key_out, attempts, 8'(inc_pulses)};
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL wrap_result got %s want %s", fmt(o), fmt(e));
        end
        while (kobs_q.size() > 0 && kexp_q.size() > 0) begin
            a = kobs_q.pop_front();
            b = kexp_q.pop_front();
            n_cmp++;
            if (a !== b) begin
                n_err++;
                $display("FAIL wrap_key got %h want %h", a, b);
            end
        end
    endtask

    task automatic test_exhaust();
        res_t e, o;
        bit ok;
        start_search(NONE, 0, NONE, 1'b1);
        exp_q.push_back('{1'b0, 1'b1, 24'h000000, 24'd1, 8'd1});
        wait_done(500, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL exhaust_done got timeout want done");
        end
        e = exp_q.pop_front();
        o = '{found, failed, key_out, attempts, 8'(inc_pulses)};
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL exhaust_result got %s want %s", fmt(o), fmt(e));
        end
        repeat (3) @(negedge clk);
        key_exhausted = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_t e, o;
        bit ok;
        start_search(NONE, 0, 24'h000002, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (key_out == 24'h000002) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok || busy !== 1'b1 || attempts !== 24'd2) begin
            n_err++;
            $display("FAIL rstmid_pre got reached=%b busy=%b att=%0d want 1 1 2", ok, busy, attempts);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, found, failed, timeout, key_start, dec_start, key_out, attempts}
            !== 54'h0) begin
            n_err++;
            $display("FAIL rstmid_clear got busy=%b key=%h att=%0d want all 0", busy, key_out, attempts);
        end
        start_search(24'h000000, 0, NONE, 1'b0);
        exp_q.push_back('{1'b1, 1'b0, 24'h000000, 24'd0, 8'd0});
        wait_done(500, ok);
        e = exp_q.pop_front();
        o = '{found, failed, key_out, attempts, 8'(inc_pulses)};
        n_cmp++;
        if (!ok || o !== e) begin
            n_err++;
            $display("FAIL rstmid_restart got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_timeout();
        start_search(NONE, 0, 24'h000000, 1'b0);
`ifdef KEY_SEARCH_TIMEOUT_EN
        repeat (16) @(negedge clk);
        n_cmp++;
        if ({busy, failed, timeout} !== 3'b100) begin
            n_err++;
            $display("FAIL tmo_before got busy/failed/timeout=%b want 100", {busy, failed, timeout});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, failed, timeout} !== 3'b011) begin
            n_err++;
            $display("FAIL tmo_fire got busy/failed/timeout=%b want 011", {busy, failed, timeout});
        end
`else
        repeat (1000) @(negedge clk);
        n_cmp++;
        if ({busy, failed, timeout} !== 3'b100) begin
            n_err++;
            $display("FAIL tmo_none got busy/failed/timeout=%b want 100", {busy, failed, timeout});
        end
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, failed, timeout} !== 3'b000) begin
            n_err++;
            $display("FAIL tmo_recover got busy/failed/timeout=%b want 000", {busy, failed, timeout});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_hit();
        test_walk_go_ignored();
        test_limit();
        test_wrap();
        test_exhaust();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
